// File: rtl/apb4_pkg.sv
// Shared types and helpers for the APB4 register completer and its register file.
package apb4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // PPROT bit that marks a privileged access.
  localparam int PPROT_PRIV = 0;

  // Widest data path merge_strb handles; narrower callers zero-extend and truncate.
  localparam int MERGE_DW = 64;
  localparam int MERGE_SW = MERGE_DW / 8;

  function automatic logic [MERGE_DW-1:0] merge_strb(
    input logic [MERGE_DW-1:0] old_v,
    input logic [MERGE_DW-1:0] new_v,
    input logic [MERGE_SW-1:0] strb
  );
    logic [MERGE_DW-1:0] res;
    res = old_v;
    for (int k = 0; k < MERGE_SW; k++) begin
      if (strb[k]) res[k*8 +: 8] = new_v[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb4_if.sv
// APB4 bus bundle between a requester (master) and a completer (slave).
interface apb4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [2:0]              PPROT;
  logic                    PREADY;
  logic                    PSLVERR;
  logic [DATA_WIDTH-1:0]   PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PREADY, PSLVERR, PRDATA
  );

endinterface

// File: rtl/apb4_reg_file.sv
// Register storage behind the completer: byte-strobed write port, constant reg 0,
// combinational read port and a flattened view of every register.
module apb4_reg_file
  import apb4_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter int                    IDX_W      = 4,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(32'hA9B4_0001)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_we,
  input  logic [IDX_W-1:0]               i_widx,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_strb,
  input  logic [IDX_W-1:0]               i_ridx,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);

  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];

  assign w_regs[0] = ID_VALUE;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_merged = DATA_WIDTH'(merge_strb(MERGE_DW'(r_q), MERGE_DW'(i_wdata),
                                             MERGE_SW'(i_strb)));

    // NOTE: these are flops, not a RAM macro, so they take the reset; a RAM would not.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= '0;
      end else if (i_we && (i_widx == IDX_W'(g))) begin
        r_q <= w_merged;
      end
    end

    assign w_regs[g] = r_q;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = w_regs[g];
  end

  assign o_rdata = w_regs[i_ridx];

endmodule

// File: rtl/apb4_reg_completer.sv
// APB4 completer for a small register bank: address decode, programmable wait states,
// byte strobes, privilege checks and PSLVERR reporting.
module apb4_reg_completer
  import apb4_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 1,
  parameter int                    PRIV_BASE   = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA9B4_0001)
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  apb4_if.slave                          apb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int WORD_W = ADDR_WIDTH - 2;
  localparam int CNT_W  = $clog2(WAIT_STATES + 2);

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_write, w_write_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [STRB_W-1:0]     r_strb, w_strb_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_pready, w_pready_nxt;
  logic                  r_pslverr, w_pslverr_nxt;
  logic [DATA_WIDTH-1:0] r_prdata, w_prdata_nxt;
  logic                  w_we;

  // Decode of the live setup-phase address; only consulted while IDLE.
  logic [WORD_W-1:0]     w_word;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_err_in;
  logic [IDX_W-1:0]      w_ridx;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused_prot;

  assign w_word = apb.PADDR[ADDR_WIDTH-1:2];
  assign w_idx  = w_word[IDX_W-1:0];

  assign w_err_in = (|apb.PADDR[1:0])
                  || (w_word >= WORD_W'(NUM_REGS))
                  || (apb.PWRITE && (w_word == '0))
                  || (apb.PWRITE && !apb.PPROT[PPROT_PRIV] && (w_word >= WORD_W'(PRIV_BASE)))
                  || (!apb.PWRITE && (|apb.PSTRB));

  assign w_unused_prot = ^apb.PPROT[2:1];

  // Zero-wait reads sample the register in the same edge as setup, before r_idx exists.
  assign w_ridx = (r_state == ST_IDLE) ? w_idx : r_idx;

  apb4_reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W),
    .ID_VALUE   (ID_VALUE)
  ) u_reg_file (
    .clk     (PCLK),
    .rst     (PRESET),
    .i_we    (w_we),
    .i_widx  (r_idx),
    .i_wdata (r_wdata),
    .i_strb  (r_strb),
    .i_ridx  (w_ridx),
    .o_rdata (w_rdata),
    .o_regs  (regs_o)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_write_nxt   = r_write;
    w_idx_nxt     = r_idx;
    w_wdata_nxt   = r_wdata;
    w_strb_nxt    = r_strb;
    w_err_nxt     = r_err;
    w_pready_nxt  = 1'b0;
    w_pslverr_nxt = 1'b0;
    w_prdata_nxt  = '0;
    w_we          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          w_write_nxt = apb.PWRITE;
          w_idx_nxt   = w_idx;
          w_wdata_nxt = apb.PWDATA;
          w_strb_nxt  = apb.PSTRB;
          w_err_nxt   = w_err_in;
          w_cnt_nxt   = CNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            w_state_nxt   = ST_DONE;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = w_err_in;
            w_prdata_nxt  = (!apb.PWRITE && !w_err_in) ? w_rdata : '0;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (!apb.PSEL) begin
          w_state_nxt = ST_IDLE;
        end else if (apb.PENABLE) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt   = ST_DONE;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = r_err;
            w_prdata_nxt  = (!r_write && !r_err) ? w_rdata : '0;
          end
        end
      end

      ST_DONE: begin
        w_we        = r_write && !r_err;
        w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_err     <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_write   <= w_write_nxt;
      r_idx     <= w_idx_nxt;
      r_wdata   <= w_wdata_nxt;
      r_strb    <= w_strb_nxt;
      r_err     <= w_err_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_prdata  <= w_prdata_nxt;
    end
  end

  assign apb.PREADY  = r_pready;
  assign apb.PSLVERR = r_pslverr;
  assign apb.PRDATA  = r_prdata;

endmodule
